// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with LATENCY wait states and valid/ready response
// Optional: `define MISALIGN_TRAP_EN adds resp_err and traps misaligned half/word accesses.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        MemRead,
    input  logic [3:0]        MemWrite,
    input  logic [31:0]       wdata,
    input  logic              MemSignExtend,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       rdata,
`ifdef MISALIGN_TRAP_EN
    output logic              resp_err,
`endif
    output logic              busy
);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
    localparam bit ZERO_LAT = (LATENCY == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        rd_q, wr_q;
    logic [31:0]       wdata_q;
    logic              sx_q;
    logic [31:0]       mem [DEPTH];

    // 0 = none, 1 = byte, 2 = half, 3 = word (unrecognised masks act as word)
    function automatic logic [1:0] size_of(input logic [3:0] m);
        case (m)
            4'b0000: size_of = 2'd0;
            4'b0001: size_of = 2'd1;
            4'b0011: size_of = 2'd2;
            default: size_of = 2'd3;
        endcase
    endfunction

    // With zero latency the access happens on the accept edge, before the request is latched.
    logic              use_in;
    logic [ADDR_W-1:0] s_addr;
    logic [3:0]        s_rd, s_wr;
    logic [31:0]       s_wdata, wshift, shifted, load_val, result;
    logic              s_sx, is_store, is_load, misaligned, in_range, access, commit;
    logic [1:0]        size, off;
    logic [3:0]        lanes;
    logic [ADDR_W-3:0] word_idx;
    logic [MEM_AW-1:0] mem_idx;

    always_comb begin
        use_in     = (state == IDLE);
        s_addr     = use_in ? addr          : addr_q;
        s_rd       = use_in ? MemRead       : rd_q;
        s_wr       = use_in ? MemWrite      : wr_q;
        s_wdata    = use_in ? wdata         : wdata_q;
        s_sx       = use_in ? MemSignExtend : sx_q;
        is_store   = (s_wr != 4'b0000);
        is_load    = !is_store && (s_rd != 4'b0000);
        size       = is_store ? size_of(s_wr) : size_of(s_rd);
        misaligned = ((size == 2'd2) && s_addr[0]) || ((size == 2'd3) && (s_addr[1:0] != 2'b00));
        off        = s_addr[1:0];
        if (size == 2'd2) off[0] = 1'b0;
        if (size == 2'd3) off = 2'b00;
        case (size)
            2'd1:    lanes = 4'b0001 << off;
            2'd2:    lanes = 4'b0011 << off;
            2'd3:    lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        word_idx = s_addr[ADDR_W-1:2];
        mem_idx  = word_idx[MEM_AW-1:0];
        in_range = ADDR_W'(word_idx) < ADDR_W'(DEPTH);
`ifdef MISALIGN_TRAP_EN
        access   = in_range && !misaligned;
`else
        access   = in_range;
`endif
        wshift   = s_wdata << {off, 3'b000};
        shifted  = mem[mem_idx] >> {off, 3'b000};
        case (size)
            2'd1:    load_val = {{24{s_sx & shifted[7]}}, shifted[7:0]};
            2'd2:    load_val = {{16{s_sx & shifted[15]}}, shifted[15:0]};
            2'd3:    load_val = shifted;
            default: load_val = 32'd0;
        endcase
        result = (is_load && access) ? load_val : 32'd0;
        commit = (ZERO_LAT && (state == IDLE) && req_valid && req_ready)
              || ((state == WAIT) && (cnt == '0));
    end

    always_ff @(posedge clock) begin
        if (reset && commit && is_store && access) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) mem[mem_idx][8*i +: 8] <= wshift[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= 32'd0;
            busy       <= 1'b0;
            cnt        <= '0;
`ifdef MISALIGN_TRAP_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    addr_q    <= addr;
                    rd_q      <= MemRead;
                    wr_q      <= MemWrite;
                    wdata_q   <= wdata;
                    sx_q      <= MemSignExtend;
                    cnt       <= CNT_INIT;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    if (ZERO_LAT) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        rdata      <= result;
`ifdef MISALIGN_TRAP_EN
                        resp_err   <= misaligned;
`endif
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == '0) begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    rdata      <= result;
`ifdef MISALIGN_TRAP_EN
                    resp_err   <= misaligned;
`endif
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (LATENCY=2)
module tb_dmem_responder;
    localparam int LATENCY = 2;

    logic        clock = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [3:0]  MemRead = '0, MemWrite = '0;
    logic        MemSignExtend = 1'b0, resp_valid, resp_ready = 1'b1, busy;
`ifdef MISALIGN_TRAP_EN
    logic        resp_err;
`endif

    dmem_responder #(.DEPTH(256), .ADDR_W(32), .LATENCY(LATENCY)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .MemRead(MemRead), .MemWrite(MemWrite), .wdata(wdata),
        .MemSignExtend(MemSignExtend), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .rdata(rdata),
`ifdef MISALIGN_TRAP_EN
        .resp_err(resp_err),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] d; logic e; int acc; } exp_t;
    exp_t q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    bit   seen = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clock) begin
        if (reset && resp_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got rdata %h with no request outstanding", rdata);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - q[0].acc), 32'(LATENCY + 1));
                    seen = 1;
                end
                if (resp_ready) begin
                    chk("rdata", rdata, q[0].d);
`ifdef MISALIGN_TRAP_EN
                    chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].e});
`endif
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(posedge clock); #1;
        while (!req_ready && n < 100) begin @(posedge clock); #1; n++; end
        chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] rd, input logic [3:0] wr,
                         input logic [31:0] wd, input logic sx, input logic [31:0] ed, input logic ee);
        exp_t x;
        wait_ready();
        addr = a; MemRead = rd; MemWrite = wr; wdata = wd; MemSignExtend = sx; req_valid = 1'b1;
        x.d = ed; x.e = ee; x.acc = cyc;
        q.push_back(x);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin @(posedge clock); #1; n++; end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;

        issue(32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        issue(32'h10, 4'hF, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        issue(32'h13, 4'h1, 4'h0, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
        issue(32'h13, 4'h1, 4'h0, 32'h0, 1'b0, 32'h000000DE, 1'b0);
        issue(32'h10, 4'h3, 4'h0, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0);
        issue(32'h12, 4'h3, 4'h0, 32'h0, 1'b0, 32'h0000DEAD, 1'b0);
        issue(32'h11, 4'h0, 4'h1, 32'h55, 1'b0, 32'h0, 1'b0);
        issue(32'h10, 4'hF, 4'h0, 32'h0, 1'b0, 32'hDEAD55EF, 1'b0);
        issue(32'h12, 4'hF, 4'h1, 32'h77, 1'b0, 32'h0, 1'b0);
        issue(32'h10, 4'hF, 4'h0, 32'h0, 1'b0, 32'hDE7755EF, 1'b0);
        issue(32'h10, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        issue(32'h13, 4'h3, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);
`else
        issue(32'h13, 4'h3, 4'h0, 32'h0, 1'b0, 32'h0000DE77, 1'b0);
`endif
        issue(32'h0, 4'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
        issue(32'h400, 4'h0, 4'hF, 32'h11111111, 1'b0, 32'h0, 1'b0);
        issue(32'h400, 4'hF, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        issue(32'h0, 4'hF, 4'h0, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0);
        issue(32'h20, 4'h0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        drain();

        // reset lands while the store is still waiting, so it must never commit
        wait_ready();
        addr = 32'h20; MemRead = 4'h0; MemWrite = 4'hF; wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (6) @(posedge clock);
        issue(32'h20, 4'hF, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
`ifdef MISALIGN_TRAP_EN
        issue(32'h22, 4'hF, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);
`else
        issue(32'h22, 4'hF, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
`endif
        drain();

        resp_ready = 1'b0;
        issue(32'h10, 4'hF, 4'h0, 32'h0, 1'b0, 32'hDE7755EF, 1'b0);
        n = 0;
        while (!resp_valid && n < 20) begin @(posedge clock); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_rdata", rdata, 32'hDE7755EF);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_hs_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("post_hs_busy", {31'd0, busy}, 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
